// File: rtl/audio_pkg.sv
// Shared constants and types for the serial audio frame controller.
// The converter frame is fixed at 2 channels x 16 bit slots, MSB first.
package audio_pkg;

  localparam int AUD_W           = 16;
  localparam int SLOTS_PER_CH    = 16;
  localparam int SLOTS_PER_FRAME = 32;
  localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);
  localparam int UR_CNT_W        = 16;

  typedef struct packed {
    logic [AUD_W-1:0] l;
    logic [AUD_W-1:0] r;
  } stereo_t;

  typedef enum logic {
    BCK_PH_HIGH = 1'b0,
    BCK_PH_LOW  = 1'b1
  } bck_phase_e;

  // The left channel occupies the first half of the frame (LRCK high).
  function automatic logic slot_is_left(input logic [SLOT_W-1:0] slot);
    return (slot < SLOT_W'(SLOTS_PER_CH));
  endfunction

endpackage

// File: rtl/audio_frame_ctrl_if.sv
// Sample-side bus of the frame controller: captured samples out, playback samples in.
interface audio_frame_ctrl_if;
  import audio_pkg::*;

  // Playback handshake: a transfer happens on a rising clock edge where
  // iPLAY_VALID and oPLAY_READY are both high; iPLAY_L/iPLAY_R must be stable
  // while iPLAY_VALID is high. Captured samples are a strobe (oSMP_VALID) with
  // no backpressure; oSMP_L/oSMP_R hold until the next strobe.
  logic [AUD_W-1:0] iPLAY_L;
  logic [AUD_W-1:0] iPLAY_R;
  logic             iPLAY_VALID;
  logic             oPLAY_READY;
  logic [AUD_W-1:0] oSMP_L;
  logic [AUD_W-1:0] oSMP_R;
  logic             oSMP_VALID;

  modport slave (
    input  iPLAY_L, iPLAY_R, iPLAY_VALID,
    output oPLAY_READY, oSMP_L, oSMP_R, oSMP_VALID
  );

  modport master (
    output iPLAY_L, iPLAY_R, iPLAY_VALID,
    input  oPLAY_READY, oSMP_L, oSMP_R, oSMP_VALID
  );

endinterface

// File: rtl/audio_bck_gen.sv
// Bit clock / LR clock generator: divides the system clock into BCK half-periods
// and walks the 32-slot frame, emitting one-cycle strobes on BCK edges.
module audio_bck_gen
  import audio_pkg::*;
#(
  parameter int BCK_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              bck,
  output logic              lrck,
  output logic              fall_evt,
  output logic              rise_evt,
  output logic [SLOT_W-1:0] slot
);

  localparam int              CNT_W   = $clog2(BCK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCK_DIV - 1);

  bck_phase_e        phase_q, phase_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              lrck_q, lrck_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= BCK_PH_HIGH;
      div_q   <= '0;
      slot_q  <= '1;
      lrck_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      lrck_q  <= lrck_d;
    end
  end

  // Events fire only on the enabled cycle that completes a half-period, so a
  // low enable freezes both the timing state and the strobes.
  always_comb begin
    phase_d  = phase_q;
    div_d    = div_q;
    slot_d   = slot_q;
    lrck_d   = lrck_q;
    fall_evt = 1'b0;
    rise_evt = 1'b0;
    if (en) begin
      if (div_q == CNT_MAX) begin
        div_d = '0;
        unique case (phase_q)
          BCK_PH_HIGH: begin
            phase_d  = BCK_PH_LOW;
            fall_evt = 1'b1;
            slot_d   = slot_q + SLOT_W'(1);
            lrck_d   = slot_is_left(slot_d);
          end
          BCK_PH_LOW: begin
            phase_d  = BCK_PH_HIGH;
            rise_evt = 1'b1;
          end
          default: phase_d = BCK_PH_HIGH;
        endcase
      end else begin
        div_d = div_q + CNT_W'(1);
      end
    end
  end

  assign bck  = (phase_q == BCK_PH_HIGH);
  assign lrck = lrck_q;
  assign slot = slot_q;

endmodule

// File: rtl/audio_frame_ctrl.sv
// Master timing and once-per-frame sample handoff between the serial audio
// converter and the sample-processing logic.
module audio_frame_ctrl
  import audio_pkg::*;
#(
  parameter int BCK_DIV = 16,
  parameter int DATA_W  = 16
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iEN,
  output logic                AUD_BCK,
  output logic                AUD_LRCK,
  input  logic [DATA_W-1:0]   AUD_inL,
  input  logic [DATA_W-1:0]   AUD_inR,
  output logic [DATA_W-1:0]   AUD_outL,
  output logic [DATA_W-1:0]   AUD_outR,
  audio_frame_ctrl_if.slave   smp_if,
  output logic                oUNDERRUN,
  output logic [UR_CNT_W-1:0] oUNDERRUN_CNT
);

  if (BCK_DIV < 2) begin : g_bad_div
    $error("audio_frame_ctrl: BCK_DIV must be at least 2");
  end
  if (DATA_W != AUD_W) begin : g_bad_width
    $error("audio_frame_ctrl: DATA_W must equal the converter width of 16");
  end

  logic              fall_evt, rise_evt, cap_evt, accept;
  logic [SLOT_W-1:0] slot;
  logic              unused_fall;

  stereo_t              smp_q, pend_q, out_q;
  logic                 smp_valid_q, pend_full_q, primed_q, underrun_q;
  logic [UR_CNT_W-1:0]  ur_cnt_q;

  audio_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck_gen (
    .clk      (iCLK),
    .rst      (iRST),
    .en       (iEN),
    .bck      (AUD_BCK),
    .lrck     (AUD_LRCK),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt),
    .slot     (slot)
  );

  assign unused_fall = fall_evt;

  // The rising edge inside the last right slot is the only point where the
  // converter word is complete and the left playback word is not yet in use.
  assign cap_evt = rise_evt && (slot == SLOT_W'(SLOTS_PER_FRAME - 1));

  assign smp_if.oPLAY_READY = !pend_full_q && !iRST;
  assign accept             = smp_if.iPLAY_VALID && smp_if.oPLAY_READY;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      smp_q       <= '0;
      smp_valid_q <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      primed_q    <= 1'b0;
      out_q       <= '0;
      underrun_q  <= 1'b0;
      ur_cnt_q    <= '0;
    end else begin
      smp_valid_q <= cap_evt;
      if (cap_evt) begin
        smp_q.l <= AUD_inL;
        smp_q.r <= AUD_inR;
      end

      // The pending state seen here is the start-of-cycle value, so a sample
      // accepted on the capture cycle waits for the next frame.
      if (cap_evt && pend_full_q) begin
        out_q       <= pend_q;
        pend_full_q <= 1'b0;
      end else if (cap_evt && primed_q) begin
        underrun_q <= 1'b1;
        if (ur_cnt_q != '1) begin
          ur_cnt_q <= ur_cnt_q + UR_CNT_W'(1);
        end
      end

      // Accept implies the buffer was empty, so it never collides with the drain.
      if (accept) begin
        pend_q.l    <= smp_if.iPLAY_L;
        pend_q.r    <= smp_if.iPLAY_R;
        pend_full_q <= 1'b1;
        primed_q    <= 1'b1;
      end
    end
  end

  assign smp_if.oSMP_L     = smp_q.l;
  assign smp_if.oSMP_R     = smp_q.r;
  assign smp_if.oSMP_VALID = smp_valid_q;
  assign AUD_outL          = out_q.l;
  assign AUD_outR          = out_q.r;
  assign oUNDERRUN         = underrun_q;
  assign oUNDERRUN_CNT     = ur_cnt_q;

endmodule

// File: tb/tb_audio_frame_ctrl.sv
// Directed bench for audio_frame_ctrl: frame timing, capture, playback buffer,
// underrun, enable freeze and mid-frame reset.
module tb_audio_frame_ctrl;
  import audio_pkg::*;

  localparam int BCK_DIV = 16;
  localparam int FRAME   = 64 * BCK_DIV;

  // clock / reset block
  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iEN;
  logic        AUD_BCK, AUD_LRCK;
  logic [15:0] AUD_inL, AUD_inR, AUD_outL, AUD_outR;
  logic        oUNDERRUN;
  logic [15:0] oUNDERRUN_CNT;

  audio_frame_ctrl_if aif ();

  audio_frame_ctrl #(
    .BCK_DIV (BCK_DIV),
    .DATA_W  (16)
  ) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iEN           (iEN),
    .AUD_BCK       (AUD_BCK),
    .AUD_LRCK      (AUD_LRCK),
    .AUD_inL       (AUD_inL),
    .AUD_inR       (AUD_inR),
    .AUD_outL      (AUD_outL),
    .AUD_outR      (AUD_outR),
    .smp_if        (aif),
    .oUNDERRUN     (oUNDERRUN),
    .oUNDERRUN_CNT (oUNDERRUN_CNT)
  );

  always #5 iCLK = ~iCLK;

  int cyc  = 0;
  int rel0 = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] play_q[$];
  logic [31:0] exp_out = '0;
  logic        prev_v  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge iCLK);
  endtask

  task automatic tick_until(input int t);
    while ((cyc - rel0) < t) tick();
  endtask

  // Waits (bounded) for a signal level and checks the cycle count since release.
  task automatic wait_sig(input string tag, input int sel, input logic lvl, input int exp_at);
    logic s;
    bit   found;
    found = 1'b0;
    for (int i = 0; i < FRAME + 200 && !found; i++) begin
      tick();
      case (sel)
        0:       s = AUD_BCK;
        1:       s = AUD_LRCK;
        default: s = aif.oSMP_VALID;
      endcase
      if (s === lvl) found = 1'b1;
    end
    chk(tag, found ? 32'(cyc - rel0) : 32'hFFFF_FFFF, 32'(exp_at));
  endtask

  task automatic offer(input string tag, input logic [15:0] l, input logic [15:0] r);
    chk({tag, "_ready_pre"}, {31'd0, aif.oPLAY_READY}, 32'd1);
    aif.iPLAY_L     = l;
    aif.iPLAY_R     = r;
    aif.iPLAY_VALID = 1'b1;
    tick();
    aif.iPLAY_VALID = 1'b0;
    chk({tag, "_ready_post"}, {31'd0, aif.oPLAY_READY}, 32'd0);
  endtask

  // Output monitor: pops capture and playback expectations at each strobe.
  always @(negedge iCLK) begin
    if (prev_v) chk("valid_one_cycle", {31'd0, aif.oSMP_VALID}, 32'd0);
    if (aif.oSMP_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, aif.oSMP_VALID}, 32'd0);
      end else begin
        chk("smp_lr", {aif.oSMP_L, aif.oSMP_R}, exp_q.pop_front());
      end
      if (play_q.size() > 0) exp_out = play_q.pop_front();
      chk("aud_out_lr", {AUD_outL, AUD_outR}, exp_out);
    end
    prev_v = (aif.oSMP_VALID === 1'b1);
  end

  initial begin
    iRST            = 1'b1;
    iEN             = 1'b1;
    AUD_inL         = '0;
    AUD_inR         = '0;
    aif.iPLAY_L     = '0;
    aif.iPLAY_R     = '0;
    aif.iPLAY_VALID = 1'b0;
    repeat (3) tick();

    chk("rst_bck",      {31'd0, AUD_BCK}, 32'd1);
    chk("rst_lrck",     {31'd0, AUD_LRCK}, 32'd0);
    chk("rst_valid",    {31'd0, aif.oSMP_VALID}, 32'd0);
    chk("rst_ready",    {31'd0, aif.oPLAY_READY}, 32'd0);
    chk("rst_smp",      {aif.oSMP_L, aif.oSMP_R}, 32'd0);
    chk("rst_out",      {AUD_outL, AUD_outR}, 32'd0);
    chk("rst_underrun", {31'd0, oUNDERRUN}, 32'd0);
    chk("rst_ur_cnt",   {16'd0, oUNDERRUN_CNT}, 32'd0);

    // Frame 1: timing from release, capture, first playback load.
    AUD_inL = 16'hA5C3;
    AUD_inR = 16'h0F1E;
    exp_q.push_back(32'hA5C3_0F1E);
    iRST = 1'b0;
    rel0 = cyc;
    wait_sig("bck_fall0", 0, 1'b0, 16);
    chk("lrck_first", {31'd0, AUD_LRCK}, 32'd1);
    offer("play0", 16'h1234, 16'h8001);
    play_q.push_back(32'h1234_8001);
    wait_sig("bck_rise0", 0, 1'b1, 32);
    wait_sig("bck_fall1", 0, 1'b0, 48);
    wait_sig("lrck_fall0", 1, 1'b0, 528);
    chk("out_before_c", {AUD_outL, AUD_outR}, 32'd0);
    wait_sig("cap0", 2, 1'b1, FRAME);
    chk("ready_after_load", {31'd0, aif.oPLAY_READY}, 32'd1);
    chk("no_underrun0", {31'd0, oUNDERRUN}, 32'd0);

    // Frame 2: no playback offered after priming -> underrun, output holds.
    AUD_inL = 16'h5A3C;
    AUD_inR = 16'hF0E1;
    exp_q.push_back(32'h5A3C_F0E1);
    wait_sig("cap1", 2, 1'b1, 2 * FRAME);
    chk("underrun1", {31'd0, oUNDERRUN}, 32'd1);
    chk("ur_cnt1",   {16'd0, oUNDERRUN_CNT}, 32'd1);

    // Frame 3: refill, then freeze timing for 100 cycles mid-slot.
    tick();
    offer("play1", 16'hBEEF, 16'h0001);
    play_q.push_back(32'hBEEF_0001);
    AUD_inL = 16'h1357;
    AUD_inR = 16'h2468;
    exp_q.push_back(32'h1357_2468);
    tick_until(2 * FRAME + 40);
    chk("frz_bck_pre",  {31'd0, AUD_BCK}, 32'd1);
    chk("frz_lrck_pre", {31'd0, AUD_LRCK}, 32'd1);
    iEN = 1'b0;
    repeat (100) tick();
    chk("frz_bck_post",  {31'd0, AUD_BCK}, 32'd1);
    chk("frz_lrck_post", {31'd0, AUD_LRCK}, 32'd1);
    iEN = 1'b1;
    wait_sig("bck_fall_frz",  0, 1'b0, 2 * FRAME + 48 + 100);
    wait_sig("lrck_fall_frz", 1, 1'b0, 2 * FRAME + 528 + 100);
    wait_sig("cap2",          2, 1'b1, 3 * FRAME + 100);
    chk("ur_cnt_hold", {16'd0, oUNDERRUN_CNT}, 32'd1);
    chk("underrun_sticky", {31'd0, oUNDERRUN}, 32'd1);

    // Fill the buffer, then reset in the middle of the left phase.
    tick();
    offer("play2", 16'h7777, 16'h3333);
    tick_until(3 * FRAME + 100 + 128);
    chk("lrck_left_mid", {31'd0, AUD_LRCK}, 32'd1);
    iRST = 1'b1;
    tick();
    chk("mrst_bck",      {31'd0, AUD_BCK}, 32'd1);
    chk("mrst_lrck",     {31'd0, AUD_LRCK}, 32'd0);
    chk("mrst_ready",    {31'd0, aif.oPLAY_READY}, 32'd0);
    chk("mrst_underrun", {31'd0, oUNDERRUN}, 32'd0);
    chk("mrst_ur_cnt",   {16'd0, oUNDERRUN_CNT}, 32'd0);
    chk("mrst_smp",      {aif.oSMP_L, aif.oSMP_R}, 32'd0);
    chk("mrst_out",      {AUD_outL, AUD_outR}, 32'd0);
    exp_out = '0;
    iRST = 1'b0;
    rel0 = cyc;
    #1;
    chk("mrst_ready_rel", {31'd0, aif.oPLAY_READY}, 32'd1);

    // After reset the buffer is unprimed: an empty frame is not an underrun.
    AUD_inL = 16'hCAFE;
    AUD_inR = 16'hD00D;
    exp_q.push_back(32'hCAFE_D00D);
    wait_sig("cap_after_rst", 2, 1'b1, FRAME);
    chk("unprimed_no_underrun", {31'd0, oUNDERRUN}, 32'd0);
    chk("unprimed_ur_cnt",      {16'd0, oUNDERRUN_CNT}, 32'd0);
    tick();

    chk("exp_q_empty",  32'(exp_q.size()), 32'd0);
    chk("play_q_empty", 32'(play_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_frame_ctrl.md
Name: audio_frame_ctrl

Overview:
- Master timing and sample-handoff stage for the serial audio converter.
- Generates AUD_BCK and AUD_LRCK from the system clock:
  - 16 bit slots per channel, MSB first.
  - LRCK high = left channel.
- Once per frame, captures the converter's deserialised AUD_inL/AUD_inR into the system domain.
- Once per frame, loads the playback sample that the converter serialises from AUD_outL/AUD_outR.
- Sits between the converter and the sample-processing logic. Playback input uses a one-entry valid/ready buffer.

Parameters:
- BCK_DIV, 16, iCLK cycles per AUD_BCK half-period. Must be >= 2. BCK = f_iCLK/(2*BCK_DIV); frame = 64*BCK_DIV cycles.
- DATA_W, 16, sample width. Fixed at 16 by the converter; checked at elaboration.

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  synchronous reset, active-high.
- iEN  in  1  run enable. Low freezes all timing state.
- AUD_BCK  out  1  bit clock to converter.
- AUD_LRCK  out  1  left/right clock to converter.
- AUD_inL  in  16  left sample deserialised by converter.
- AUD_inR  in  16  right sample deserialised by converter.
- AUD_outL  out  16  left playback sample to converter.
- AUD_outR  out  16  right playback sample to converter.
- oSMP_L  out  16  captured left sample.
- oSMP_R  out  16  captured right sample.
- oSMP_VALID  out  1  one-cycle strobe, once per frame.
- iPLAY_L  in  16  playback left sample.
- iPLAY_R  in  16  playback right sample.
- iPLAY_VALID  in  1  playback sample offered.
- oPLAY_READY  out  1  buffer can accept.
- oUNDERRUN  out  1  sticky underrun flag.
- oUNDERRUN_CNT  out  16  saturating underrun count.

Behaviour:
- Reset (iRST=1, synchronous):
  - AUD_BCK=1, AUD_LRCK=0.
  - div_cnt=0, slot=31.
  - All sample outputs 0, oSMP_VALID=0.
  - Pending buffer empty, primed=0.
  - oUNDERRUN=0, oUNDERRUN_CNT=0.
  - oPLAY_READY forced 0 while iRST=1.
- Divider (only while iEN=1):
  - div_cnt counts 0..BCK_DIV-1.
  - At BCK_DIV-1: div_cnt wraps to 0 and AUD_BCK toggles.
  - iEN=0 holds div_cnt, BCK, LRCK and slot. No events fire.
- Falling event F (BCK 1->0):
  - slot <= slot+1, wrapping 31->0.
  - AUD_LRCK <= (new slot < 16).
  - First F after reset therefore enters slot 0 with LRCK=1.
- Capture event C = rising BCK edge while slot==31 (last right slot; all 32 converter bits written). At C:
  - oSMP_L <= AUD_inL, oSMP_R <= AUD_inR.
  - oSMP_VALID=1 for exactly one cycle.
  - No backpressure on the capture side.
  - First oSMP_VALID edge is 64*BCK_DIV cycles after reset release (1024 cycles at default).
- Playback buffer:
  - One entry. oPLAY_READY = !pend_full && !iRST.
  - Accept = iPLAY_VALID && oPLAY_READY. Stores L/R, sets pend_full and primed.
- At each C, the pending state is sampled at the start of the cycle:
  - If full: AUD_outL/AUD_outR <= pending; pend_full cleared.
  - If empty: AUD_outL/AUD_outR hold their previous value. If primed=1, set oUNDERRUN and increment oUNDERRUN_CNT, saturating at 0xFFFF.
- Simultaneous accept and C with buffer empty:
  - C reports underrun (if primed).
  - The accepted sample enters pending and loads at the next C.
  - There is no bypass.
- AUD_outL/AUD_outR change only at C, during the last right slot, so left serialisation always sees a stable word.
- Reset mid-frame returns to reset state immediately. No partial sample is presented; oSMP_VALID is not asserted.
- oUNDERRUN clears only on reset.

Decomposition:
- Shared package audio_pkg:
  - AUD_W=16, SLOTS_PER_CH=16, SLOTS_PER_FRAME=32.
  - Type for the stereo sample pair {L,R}.
- One natural sub-module: audio_bck_gen.
  - Contains div_cnt, BCK, LRCK and slot.
  - Outputs one-cycle fall_evt/rise_evt strobes and slot.
- The parent holds the capture registers, pending buffer and underrun logic.

Test Plan:
- Reset release, BCK_DIV=16, iEN=1 -> first BCK fall 16 cycles after release, LRCK=1; BCK period 32 cycles; LRCK toggles every 512 cycles; first oSMP_VALID edge 1024 cycles after release.
- Converter model drives AUD_inL=0xA5C3, AUD_inR=0x0F1E -> at C, oSMP_L=0xA5C3, oSMP_R=0x0F1E with a single-cycle oSMP_VALID; repeats every 1024 cycles.
- Offer iPLAY 0x1234/0x8001 while buffer empty -> accepted immediately, oPLAY_READY drops; at next C, AUD_outL=0x1234, AUD_outR=0x8001 and oPLAY_READY returns to 1.
- After priming, skip one frame of playback -> AUD_out holds its last value; oUNDERRUN=1, oUNDERRUN_CNT=1. Same with primed=0 -> no underrun.
- iEN low for 100 cycles mid-slot -> BCK, LRCK and slot frozen; all later edges delayed by exactly 100 cycles.
- iRST pulsed mid-left-phase with buffer full -> next cycle BCK=1, LRCK=0, buffer empty, counters 0; no oSMP_VALID until 1024 cycles after release.
